// File: rtl/eth_clk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eth_clk_pkg
//  Description : Shared types, default thresholds and the edge-count
//                classifier for the RGMII RX clock speed detector.
//  Revision    : 1.0 - initial release
// ============================================================================
package eth_clk_pkg;

    // Speed encoding matches the MAC speed-mode select
    typedef enum logic [1:0] {
        SPEED_10M  = 2'd0,
        SPEED_100M = 2'd1,
        SPEED_1G   = 2'd2,
        SPEED_NONE = 2'd3
    } eth_speed_e;

    // Window of 1024 cycles at 125 MHz; rx_clk/8 toggles give 2 edges per
    // 8 rx_clk periods, so nominal counts are 256 / 51.2 / 5.12.
    localparam int unsigned c_WINDOW_CYCLES  = 1024;
    localparam int unsigned c_TH_1G_MIN      = 224;
    localparam int unsigned c_TH_1G_MAX      = 288;
    localparam int unsigned c_TH_100M_MIN    = 40;
    localparam int unsigned c_TH_100M_MAX    = 64;
    localparam int unsigned c_TH_10M_MIN     = 3;
    localparam int unsigned c_TH_10M_MAX     = 8;
    localparam int unsigned c_STABLE_WINDOWS = 2;

    // Map an edge count onto a speed; out-of-band counts (including 0) mean
    // no usable clock.
    function automatic eth_speed_e classify(
        input int unsigned cnt,
        input int unsigned th_1g_min,
        input int unsigned th_1g_max,
        input int unsigned th_100m_min,
        input int unsigned th_100m_max,
        input int unsigned th_10m_min,
        input int unsigned th_10m_max
    );
        eth_speed_e s;
        if (cnt >= th_1g_min && cnt <= th_1g_max)
            s = SPEED_1G;
        else if (cnt >= th_100m_min && cnt <= th_100m_max)
            s = SPEED_100M;
        else if (cnt >= th_10m_min && cnt <= th_10m_max)
            s = SPEED_10M;
        else
            s = SPEED_NONE;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_clk_edge_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : eth_clk_edge_cnt
//  Description : Counts level changes of the synchronised RX toggle over a
//                fixed window of local clock cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_clk_edge_cnt #(
    parameter int unsigned WINDOW_CYCLES = 1024,
    parameter int unsigned CW            = $clog2(WINDOW_CYCLES + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          rx_tgl_i,
    output logic          win_end_o,   // last cycle of the current window
    output logic [CW-1:0] win_cnt_o,   // count including this cycle's edge
    output logic [CW-1:0] cap_cnt_o,   // count of the last completed window
    output logic          cap_vld_o    // one-cycle strobe with cap_cnt_o update
);

    localparam int unsigned WW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WW-1:0] c_WIN_LAST = WW'(WINDOW_CYCLES - 1);
    localparam logic [CW-1:0] c_CNT_MAX  = '1;

    logic          tgl_q;
    logic [WW-1:0] win_q;
    logic [CW-1:0] edge_cnt_q;
    logic [CW-1:0] edge_cnt_d;
    logic [CW-1:0] cap_q;
    logic          vld_q;
    logic          edge_w;
    logic          win_end_w;

    // Both toggle polarities are edges; the counter saturates rather than wraps
    always_comb begin
        edge_w     = rx_tgl_i ^ tgl_q;
        win_end_w  = en_i && (win_q == c_WIN_LAST);
        edge_cnt_d = edge_cnt_q;
        if (edge_w && (edge_cnt_q != c_CNT_MAX))
            edge_cnt_d = edge_cnt_q + CW'(1);
    end

    // Toggle history, window/edge counters and end-of-window capture
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tgl_q      <= 1'b0;
            win_q      <= '0;
            edge_cnt_q <= '0;
            cap_q      <= '0;
            vld_q      <= 1'b0;
        end else begin
            tgl_q <= rx_tgl_i;
            vld_q <= 1'b0;
            if (!en_i) begin
                win_q      <= '0;
                edge_cnt_q <= '0;
            end else if (win_end_w) begin
                win_q      <= '0;
                edge_cnt_q <= '0;
                cap_q      <= edge_cnt_d;
                vld_q      <= 1'b1;
            end else begin
                win_q      <= win_q + WW'(1);
                edge_cnt_q <= edge_cnt_d;
            end
        end
    end

    assign win_end_o = win_end_w;
    assign win_cnt_o = edge_cnt_d;
    assign cap_cnt_o = cap_q;
    assign cap_vld_o = vld_q;

endmodule
`default_nettype wire

// File: rtl/eth_rx_clk_speed_detect.sv
`default_nettype none
// ============================================================================
//  Module      : eth_rx_clk_speed_detect
//  Description : Classifies the PHY RX clock as 1G/100M/10M/none by counting
//                its divided toggle against the local 125 MHz clock, with a
//                debounce over consecutive identical windows.
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_rx_clk_speed_detect
    import eth_clk_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES  = c_WINDOW_CYCLES,
    parameter int unsigned TH_1G_MIN      = c_TH_1G_MIN,
    parameter int unsigned TH_1G_MAX      = c_TH_1G_MAX,
    parameter int unsigned TH_100M_MIN    = c_TH_100M_MIN,
    parameter int unsigned TH_100M_MAX    = c_TH_100M_MAX,
    parameter int unsigned TH_10M_MIN     = c_TH_10M_MIN,
    parameter int unsigned TH_10M_MAX     = c_TH_10M_MAX,
    parameter int unsigned STABLE_WINDOWS = c_STABLE_WINDOWS
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 en_i,
    input  logic                                 rx_tgl_i,
    output logic [1:0]                           speed_o,
    output logic                                 link_clk_ok_o,
    output logic                                 speed_change_o,
    output logic [$clog2(WINDOW_CYCLES+1)-1:0]   edge_cnt_o
);

    localparam int unsigned CW = $clog2(WINDOW_CYCLES + 1);
    localparam int unsigned SW = $clog2(STABLE_WINDOWS + 1);
    localparam logic [SW-1:0] c_STAB_MAX = SW'(STABLE_WINDOWS);

    logic          win_end;
    logic [CW-1:0] win_cnt;
    logic [CW-1:0] cap_cnt;
    logic          cap_vld;
    eth_speed_e    cls;

    eth_speed_e    cand_q;
    logic [SW-1:0] stab_q;
    eth_speed_e    speed_q;
    logic          ok_q;
    logic          chg_q;

    eth_clk_edge_cnt #(
        .WINDOW_CYCLES (WINDOW_CYCLES),
        .CW            (CW)
    ) u_edge_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (en_i),
        .rx_tgl_i  (rx_tgl_i),
        .win_end_o (win_end),
        .win_cnt_o (win_cnt),
        .cap_cnt_o (cap_cnt),
        .cap_vld_o (cap_vld)
    );

    // Classify the count that closes the current window
    always_comb begin
        cls = classify(32'(win_cnt), TH_1G_MIN, TH_1G_MAX, TH_100M_MIN,
                       TH_100M_MAX, TH_10M_MIN, TH_10M_MAX);
    end

    // Debounce FSM: commit a new speed only after enough matching windows.
    // The commit happens on the capture strobe, one cycle after window end.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cand_q  <= SPEED_NONE;
            stab_q  <= '0;
            speed_q <= SPEED_NONE;
            ok_q    <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            chg_q <= 1'b0;
            if (!en_i) begin
                cand_q <= SPEED_NONE;
                stab_q <= '0;
            end else begin
                if (win_end) begin
                    if (cls == cand_q) begin
                        if (stab_q != c_STAB_MAX)
                            stab_q <= stab_q + SW'(1);
                    end else begin
                        cand_q <= cls;
                        stab_q <= SW'(1);
                    end
                end
                if (cap_vld && (stab_q == c_STAB_MAX) && (cand_q != speed_q)) begin
                    speed_q <= cand_q;
                    ok_q    <= (cand_q != SPEED_NONE);
                    chg_q   <= 1'b1;
                end
            end
        end
    end

    assign speed_o        = speed_q;
    assign link_clk_ok_o  = ok_q;
    assign speed_change_o = chg_q;
    assign edge_cnt_o     = cap_cnt;

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_clk_speed_detect.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eth_rx_clk_speed_detect
//  Description : Directed self-checking bench for the RX clock speed
//                detector (1G/100M/10M lock, lost clock, glitch window,
//                enable gap, mid-window reset).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_rx_clk_speed_detect;

    logic        clk_i    = 1'b0;
    logic        rst_i    = 1'b1;
    logic        en_i     = 1'b1;
    logic        rx_tgl_i = 1'b0;
    logic [1:0]  speed_o;
    logic        link_clk_ok_o;
    logic        speed_change_o;
    logic [10:0] edge_cnt_o;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int cyc    = 0;
    int period = 0;   // toggle period in clk cycles, 0 = stopped

    eth_rx_clk_speed_detect u_dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .en_i           (en_i),
        .rx_tgl_i       (rx_tgl_i),
        .speed_o        (speed_o),
        .link_clk_ok_o  (link_clk_ok_o),
        .speed_change_o (speed_change_o),
        .edge_cnt_o     (edge_cnt_o)
    );

    always #4 clk_i = ~clk_i;

    // Toggle generator, updated 2 time units after each rising edge so the
    // main sequence (1 unit after the edge) always changes period first.
    initial begin : g_tgl_gen
        int ph;
        int last_p;
        ph     = 0;
        last_p = 0;
        forever begin
            @(posedge clk_i);
            #2;
            if (period != last_p) begin
                last_p = period;
                ph     = 0;
            end
            if (period != 0) begin
                ph++;
                if (ph >= period) begin
                    ph       = 0;
                    rx_tgl_i = ~rx_tgl_i;
                end
            end
        end
    end

    // Count change pulses seen on the falling edge
    initial begin : g_pulse_mon
        forever begin
            @(negedge clk_i);
            if (speed_change_o === 1'b1)
                pulses++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to clock edge number t (counted from reset release), sampling 1 unit after it
    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk_i);
            #1;
            cyc++;
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_speed", 32'(speed_o), 3);
        chk("rst_ok",    32'(link_clk_ok_o), 0);
        chk("rst_chg",   32'(speed_change_o), 0);
        chk("rst_cnt",   32'(edge_cnt_o), 0);
        rst_i  = 1'b0;
        period = 4;
        cyc    = 0;

        // ---------------- 1G lock from reset ----------------
        goto(1024);
        chk("g1_cnt_w1",   32'(edge_cnt_o), 256);
        chk("g1_speed_w1", 32'(speed_o), 3);
        goto(2048);
        chk("g1_speed_2048", 32'(speed_o), 3);
        chk("g1_chg_2048",   32'(speed_change_o), 0);
        goto(2049);
        chk("g1_speed_2049", 32'(speed_o), 2);
        chk("g1_chg_2049",   32'(speed_change_o), 1);
        chk("g1_ok_2049",    32'(link_clk_ok_o), 1);
        goto(2050);
        chk("g1_chg_2050", 32'(speed_change_o), 0);
        chk("g1_pulses",   32'(pulses), 1);

        // ---------------- 100M ----------------
        goto(3072);
        period = 20;
        goto(4096);
        chk("m100_cnt", 32'(edge_cnt_o == 11'd51 || edge_cnt_o == 11'd52), 1);
        goto(5120);
        chk("m100_speed_before", 32'(speed_o), 2);
        goto(5121);
        chk("m100_speed", 32'(speed_o), 1);
        chk("m100_chg",   32'(speed_change_o), 1);

        // ---------------- 10M ----------------
        goto(6144);
        period = 200;
        goto(7168);
        chk("m10_cnt", 32'(edge_cnt_o == 11'd5 || edge_cnt_o == 11'd6), 1);
        goto(8192);
        chk("m10_speed_before", 32'(speed_o), 1);
        goto(8193);
        chk("m10_speed", 32'(speed_o), 0);
        chk("m10_chg",   32'(speed_change_o), 1);
        chk("m10_ok",    32'(link_clk_ok_o), 1);
        goto(9216);
        chk("m10_pulses", 32'(pulses), 3);

        // ---------------- back to 1G, then lose the clock ----------------
        period = 4;
        goto(11265);
        chk("relock_speed", 32'(speed_o), 2);
        goto(12288);
        period = 0;
        goto(13312);
        chk("lost_cnt",   32'(edge_cnt_o), 0);
        chk("lost_speed_w1", 32'(speed_o), 2);
        goto(14337);
        chk("lost_speed", 32'(speed_o), 3);
        chk("lost_ok",    32'(link_clk_ok_o), 0);
        chk("lost_chg",   32'(speed_change_o), 1);

        // ---------------- single out-of-band window ----------------
        period = 4;
        goto(16385);
        chk("glitch_lock", 32'(speed_o), 2);
        goto(17408);
        chk("glitch_pulses_pre", 32'(pulses), 6);
        period = 10;
        goto(18432);
        chk("glitch_cnt", 32'(edge_cnt_o == 11'd102 || edge_cnt_o == 11'd103), 1);
        chk("glitch_speed_bad", 32'(speed_o), 2);
        period = 4;
        goto(20480);
        chk("glitch_speed", 32'(speed_o), 2);
        chk("glitch_pulses", 32'(pulses), 6);
        chk("glitch_cnt_good", 32'(edge_cnt_o), 256);

        // ---------------- enable gap ----------------
        period = 10;
        goto(21504);
        period = 4;
        goto(22004);
        en_i = 1'b0;
        goto(22104);
        chk("en_speed_hold", 32'(speed_o), 2);
        chk("en_ok_hold",    32'(link_clk_ok_o), 1);
        chk("en_cnt_hold",   32'(edge_cnt_o == 11'd102 || edge_cnt_o == 11'd103), 1);
        chk("en_chg",        32'(speed_change_o), 0);
        en_i = 1'b1;
        goto(23127);
        chk("en_cnt_pre", 32'(edge_cnt_o == 11'd102 || edge_cnt_o == 11'd103), 1);
        goto(23128);
        chk("en_cnt_new", 32'(edge_cnt_o), 256);
        goto(24152);
        chk("en_speed_after", 32'(speed_o), 2);
        chk("en_pulses",      32'(pulses), 6);

        // ---------------- reset mid-window ----------------
        goto(24452);
        rst_i = 1'b1;
        #1;
        chk("mrst_speed", 32'(speed_o), 3);
        chk("mrst_ok",    32'(link_clk_ok_o), 0);
        chk("mrst_chg",   32'(speed_change_o), 0);
        chk("mrst_cnt",   32'(edge_cnt_o), 0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        cyc   = 0;
        goto(2048);
        chk("mrst_speed_2048", 32'(speed_o), 3);
        goto(2049);
        chk("mrst_speed_2049", 32'(speed_o), 2);
        chk("mrst_chg_2049",   32'(speed_change_o), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
